// File: rtl/key_event_detector.sv
// Keypad front end: synchronises and debounces N raw key lines, then turns the
// accepted vector into single-cycle press/release/multi-key events with auto-repeat.
module key_event_detector #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_RATE     = 10_000_000,
  localparam int unsigned IDX_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [IDX_W-1:0]  key_idx,
  output logic              key_valid,
  output logic              multi_err
);

  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [RPT_W-1:0] DLY_TOP  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] RATE_TOP = RPT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_REPEAT,
    S_BLOCKED
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] cand_q;
  logic [N_KEYS-1:0] cand_d;
  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] stable_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  state_e            state_q;
  logic [RPT_W-1:0]  rpt_q;
  logic [IDX_W-1:0]  key_idx_q;
  logic              press_q;
  logic              release_q;
  logic              valid_q;
  logic              multi_q;

  logic              is_zero;
  logic              is_onehot;
  logic              is_multi;
  logic [IDX_W-1:0]  enc_idx;
  logic [N_KEYS-1:0] held_mask;

  // Front end: two-flop synchroniser followed by whole-vector debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cand_d   = sync2_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q == CNT_TOP) begin
      stable_d = cand_q;
    end
  end

  // Classification of the accepted vector
  always_comb begin
    is_zero   = (stable_q == '0);
    is_onehot = !is_zero && ((stable_q & (stable_q - N_KEYS'(1))) == '0);
    is_multi  = !is_zero && !is_onehot;
    enc_idx   = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (stable_q[i]) begin
        enc_idx = IDX_W'(i);
      end
    end
    held_mask = N_KEYS'(1) << key_idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rpt_q     <= '0;
      key_idx_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (is_onehot) begin
            press_q   <= 1'b1;
            key_idx_q <= enc_idx;
            valid_q   <= 1'b1;
            rpt_q     <= '0;
            state_q   <= S_HELD;
          end else if (is_multi) begin
            multi_q <= 1'b1;
            rpt_q   <= '0;
            state_q <= S_BLOCKED;
          end
        end

        S_HELD, S_REPEAT: begin
          if (stable_q == held_mask) begin
            // Counter compares against top-1 so pulses land exactly DELAY/RATE cycles apart
            if (state_q == S_HELD) begin
              if (rpt_q == DLY_TOP) begin
                if (REPEAT_RATE != 0) begin
                  press_q <= 1'b1;
                  rpt_q   <= '0;
                  state_q <= S_REPEAT;
                end
              end else begin
                rpt_q <= rpt_q + RPT_W'(1);
              end
            end else begin
              if (rpt_q == RATE_TOP) begin
                press_q <= 1'b1;
                rpt_q   <= '0;
              end else begin
                rpt_q <= rpt_q + RPT_W'(1);
              end
            end
          end else begin
            release_q <= 1'b1;
            multi_q   <= is_multi;
            valid_q   <= 1'b0;
            rpt_q     <= '0;
            state_q   <= is_zero ? S_IDLE : S_BLOCKED;
          end
        end

        S_BLOCKED: begin
          if (is_zero) begin
            rpt_q   <= '0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          rpt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign key_idx       = key_idx_q;
  assign key_valid     = valid_q;
  assign multi_err     = multi_q;

endmodule

// File: tb/tb_key_event_detector.sv
// Directed bench for key_event_detector: logs output events by cycle number and
// compares them with hand-computed cycle offsets and key indices.
module tb_key_event_detector;

  logic       clk;
  logic       rst;
  logic [7:0] key;
  logic       press_pulse;
  logic       release_pulse;
  logic [2:0] key_idx;
  logic       key_valid;
  logic       multi_err;

  int unsigned n_chk;
  int unsigned n_bad;
  int unsigned cyc;
  int unsigned overlap;
  int unsigned multi_alone;

  int unsigned press_cyc[$];
  int unsigned press_idx[$];
  int unsigned rel_cyc[$];
  int unsigned multi_cyc[$];

  key_event_detector #(
    .N_KEYS          (8),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_idx       (key_idx),
    .key_valid     (key_valid),
    .multi_err     (multi_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (press_pulse) begin
        press_cyc.push_back(cyc);
        press_idx.push_back(int'(key_idx));
      end
      if (release_pulse) rel_cyc.push_back(cyc);
      if (multi_err) multi_cyc.push_back(cyc);
      if (press_pulse && release_pulse) overlap = overlap + 1;
      if (multi_err && !release_pulse && press_pulse) multi_alone = multi_alone + 1;
    end
  end

  task automatic chk_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned qget(input int unsigned q[$], input int unsigned i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Key changes at a negedge; the next posedge is the first sampling edge, so the
  // event lands on the negedge where cyc == change_cyc + 8 (DEBOUNCE_CYCLES + 4).
  task automatic set_key(input logic [7:0] v, output int unsigned t);
    @(negedge clk);
    key = v;
    t = cyc;
  endtask

  task automatic clr_log();
    press_cyc.delete();
    press_idx.delete();
    rel_cyc.delete();
    multi_cyc.delete();
  endtask

  int unsigned t0, t1, tf, tr;
  int unsigned rep_off[7] = '{0, 20, 25, 30, 35, 40, 45};

  initial begin
    n_chk = 0;
    n_bad = 0;
    overlap = 0;
    multi_alone = 0;
    rst = 1'b0;
    key = '0;
    wait_cyc(3);
    chk_eq("rst_press", press_pulse, 0);
    chk_eq("rst_release", release_pulse, 0);
    chk_eq("rst_idx", key_idx, 0);
    chk_eq("rst_valid", key_valid, 0);
    chk_eq("rst_multi", multi_err, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(10);

    // Press and release of key 3, released before the first repeat is due
    clr_log();
    set_key(8'h08, t0);
    wait_cyc(11);
    chk_eq("pr_valid_held", key_valid, 1);
    set_key(8'h00, t1);
    wait_cyc(14);
    chk_eq("pr_press_cnt", press_cyc.size(), 1);
    chk_eq("pr_press_cyc", qget(press_cyc, 0), t0 + 8);
    chk_eq("pr_idx", qget(press_idx, 0), 3);
    chk_eq("pr_rel_cnt", rel_cyc.size(), 1);
    chk_eq("pr_rel_cyc", qget(rel_cyc, 0), t1 + 8);
    chk_eq("pr_multi_cnt", multi_cyc.size(), 0);
    chk_eq("pr_valid_after", key_valid, 0);
    chk_eq("pr_idx_hold", key_idx, 3);

    // Bounce on key 0: 2-cycle runs never pass the 4-cycle debounce
    clr_log();
    for (int i = 0; i < 10; i++) begin
      set_key((i % 2 == 0) ? 8'h01 : 8'h00, tf);
      wait_cyc(1);
    end
    set_key(8'h01, tf);
    wait_cyc(11);
    set_key(8'h00, t1);
    wait_cyc(14);
    chk_eq("bn_press_cnt", press_cyc.size(), 1);
    chk_eq("bn_press_cyc", qget(press_cyc, 0), tf + 8);
    chk_eq("bn_idx", qget(press_idx, 0), 0);
    chk_eq("bn_rel_cnt", rel_cyc.size(), 1);
    chk_eq("bn_multi_cnt", multi_cyc.size(), 0);

    // Auto-repeat on key 7: release reaches the FSM 48 cycles after the first press
    clr_log();
    set_key(8'h80, t0);
    wait_cyc(35);
    chk_eq("ar_valid", key_valid, 1);
    wait_cyc(12);
    set_key(8'h00, t1);
    wait_cyc(14);
    chk_eq("ar_press_cnt", press_cyc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk_eq($sformatf("ar_press_cyc%0d", i), qget(press_cyc, i), t0 + 8 + rep_off[i]);
      chk_eq($sformatf("ar_idx%0d", i), qget(press_idx, i), 7);
    end
    chk_eq("ar_rel_cnt", rel_cyc.size(), 1);
    chk_eq("ar_rel_cyc", qget(rel_cyc, 0), t1 + 8);
    chk_eq("ar_multi_cnt", multi_cyc.size(), 0);

    // Multi-key from idle, then a one-hot without release, then a clean press
    clr_log();
    set_key(8'h05, t0);
    wait_cyc(13);
    chk_eq("mk_valid_blk", key_valid, 0);
    set_key(8'h04, t1);
    wait_cyc(15);
    chk_eq("mk_press_blk", press_cyc.size(), 0);
    chk_eq("mk_rel_blk", rel_cyc.size(), 0);
    chk_eq("mk_multi_cnt", multi_cyc.size(), 1);
    chk_eq("mk_multi_cyc", qget(multi_cyc, 0), t0 + 8);
    set_key(8'h00, t1);
    wait_cyc(13);
    set_key(8'h04, tf);
    wait_cyc(11);
    set_key(8'h00, t1);
    wait_cyc(14);
    chk_eq("mk_press_cnt", press_cyc.size(), 1);
    chk_eq("mk_press_cyc", qget(press_cyc, 0), tf + 8);
    chk_eq("mk_idx", qget(press_idx, 0), 2);
    chk_eq("mk_rel_cnt", rel_cyc.size(), 1);
    chk_eq("mk_multi_end", multi_cyc.size(), 1);

    // Displacement: key 1 held, then key 4 directly
    clr_log();
    set_key(8'h02, t0);
    wait_cyc(11);
    set_key(8'h10, t1);
    wait_cyc(15);
    chk_eq("dp_valid_blk", key_valid, 0);
    chk_eq("dp_press_cnt", press_cyc.size(), 1);
    chk_eq("dp_idx", qget(press_idx, 0), 1);
    chk_eq("dp_rel_cnt", rel_cyc.size(), 1);
    chk_eq("dp_rel_cyc", qget(rel_cyc, 0), t1 + 8);
    chk_eq("dp_multi_cnt", multi_cyc.size(), 0);
    set_key(8'h00, tf);
    wait_cyc(14);
    chk_eq("dp_press_end", press_cyc.size(), 1);
    chk_eq("dp_rel_end", rel_cyc.size(), 1);

    // Asynchronous reset in the middle of auto-repeat, key kept held
    clr_log();
    set_key(8'h80, t0);
    wait_cyc(30);
    chk_eq("ra_valid_pre", key_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_eq("ra_valid_async", key_valid, 0);
    chk_eq("ra_idx_async", key_idx, 0);
    chk_eq("ra_press_async", press_pulse, 0);
    chk_eq("ra_rel_async", release_pulse, 0);
    wait_cyc(2);
    clr_log();
    @(negedge clk);
    rst = 1'b1;
    tr = cyc;
    wait_cyc(11);
    set_key(8'h00, t1);
    wait_cyc(14);
    chk_eq("ra_press_cnt", press_cyc.size(), 1);
    chk_eq("ra_press_cyc", qget(press_cyc, 0), tr + 8);
    chk_eq("ra_idx", qget(press_idx, 0), 7);
    chk_eq("ra_rel_cnt", rel_cyc.size(), 1);
    chk_eq("ra_rel_cyc", qget(rel_cyc, 0), t1 + 8);

    chk_eq("press_rel_overlap", overlap, 0);
    chk_eq("multi_with_press", multi_alone, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
